bcd_sub: RTL and testbench
==========================

BCD_SUB -- requirements
Module: bcd_sub

Interface
REQ-001 Parameter: DIGITS, default 2, number of packed BCD digits per operand (4 bits each); must be >= 1.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst  input  1  synchronous active-high reset, sampled only on the rising clk edge.
REQ-004 Port: a  input  DIGITS*4  minuend, packed BCD, digit 0 in bits [3:0].
REQ-005 Port: b  input  DIGITS*4  subtrahend, packed BCD, same packing as a.
REQ-006 Port: ci  input  1  borrow-in, subtracted at digit 0.
REQ-007 Port: o  output  DIGITS*4  registered packed-BCD difference.
REQ-008 Port: c  output  1  registered borrow-out from the most significant digit.

Function
REQ-009 The block SHALL compute o = (a - b - ci) mod 10^DIGITS in BCD and set c = 1 exactly when a < b + ci, for valid BCD inputs.
REQ-010 Per-digit rule: t = a_i - b_i - borrow_in_i, signed; if t < 0, o_i = t + 10 and borrow_out_i = 1; otherwise o_i = t and borrow_out_i = 0.
REQ-011 borrow_in_0 = ci; borrow_in_i = borrow_out_(i-1); c = borrow_out_(DIGITS-1).
REQ-012 The borrow chain SHALL ripple combinationally within one cycle, with no internal pipelining.
REQ-013 Input digits > 9 SHALL be processed by the same rule, with o_i = low 4 bits of the corrected t, giving a deterministic result with no X propagation.
REQ-014 Latency: o and c SHALL update on the rising clk edge after a, b and ci are sampled, which is 1 cycle; a new operation is accepted every cycle.
REQ-015 There is no handshake: every cycle is a valid operation, and the outputs hold their value until the next edge.
REQ-016 If rst and new operands are present on the same edge, rst SHALL win.

Reset
REQ-017 While rst = 1 at a rising edge, o SHALL load 0 and c SHALL load 0.
REQ-018 The first operation after reset deasserts SHALL produce its result on the following edge, with no extra warm-up cycles.
REQ-019 Asserting reset mid-stream SHALL discard the in-flight result; no pending result appears after reset.

Structure
REQ-020 A shared package SHALL define the BCD digit width constant (4), a bcd_digit_t typedef and the radix constant (10).
REQ-021 One sub-module bcd_digit_sub SHALL implement REQ-010 for a single digit (ports: a, b, bin, o, bout; purely combinational).
REQ-022 bcd_sub SHALL instantiate DIGITS copies of bcd_digit_sub in a generate loop, chain their borrows, and register o and c.

Verification
REQ-023 DIGITS=2: a=0x45, b=0x23, ci=0 -> next cycle o=0x22, c=0.
REQ-024 a=0x23, b=0x45, ci=0 -> o=0x78, c=1; a=0x50, b=0x01, ci=0 -> o=0x49, c=0 (borrow between digits).
REQ-025 a=0x00, b=0x00, ci=1 -> o=0x99, c=1; a=0x99, b=0x99, ci=0 -> o=0x00, c=0.
REQ-026 Back-to-back operands on consecutive cycles -> each result appears exactly 1 cycle later, in order.
REQ-027 rst=1 together with a=0x23, b=0x45 -> o=0x00, c=0 on that edge; the next operation without rst yields its correct result 1 cycle later.
REQ-028 Random valid-BCD sweep for DIGITS=2 and DIGITS=4, checked against a decimal reference model including ci and the borrow-out.

Source files
------------

// File: rtl/bcd_sub_pkg.sv
// Shared BCD constants and the digit type used by the BCD subtractor.
package bcd_sub_pkg;
  localparam int DIGIT_W = 4;
  localparam int RADIX   = 10;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;
endpackage

// File: rtl/bcd_sub_digit.sv
// Single BCD digit subtractor: o = a - b - bin, corrected by +10 on borrow.
module bcd_digit_sub
  import bcd_sub_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       bin,
  output bcd_digit_t o,
  output logic       bout
);
  // Difference spans -16..15, so a 5-bit two's-complement value holds it exactly.
  logic [DIGIT_W:0] t;

  always_comb begin
    t    = {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, bin};
    bout = t[DIGIT_W];
    o    = t[DIGIT_W-1:0] + (bout ? DIGIT_W'(RADIX) : '0);
  end
endmodule

// File: rtl/bcd_sub.sv
// Multi-digit packed BCD subtractor with a combinational borrow ripple and registered result.
module bcd_sub
  import bcd_sub_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DIGITS*DIGIT_W-1:0] a,
  input  logic [DIGITS*DIGIT_W-1:0] b,
  input  logic                    ci,
  output logic [DIGITS*DIGIT_W-1:0] o,
  output logic                    c
);
  logic [DIGITS:0]                 bw;
  logic [DIGITS*DIGIT_W-1:0]       o_d, o_q;
  logic                            c_d, c_q;

  assign bw[0] = ci;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit_sub u_dig (
      .a    (a[i*DIGIT_W +: DIGIT_W]),
      .b    (b[i*DIGIT_W +: DIGIT_W]),
      .bin  (bw[i]),
      .o    (o_d[i*DIGIT_W +: DIGIT_W]),
      .bout (bw[i+1])
    );
  end

  assign c_d = bw[DIGITS];

  always_ff @(posedge clk) begin
    if (rst) begin
      o_q <= '0;
      c_q <= 1'b0;
    end else begin
      o_q <= o_d;
      c_q <= c_d;
    end
  end

  assign o = o_q;
  assign c = c_q;
endmodule

// File: tb/tb_bcd_sub.sv
// Directed and decimal-model checks of bcd_sub at DIGITS=2 and DIGITS=4.
module tb_bcd_sub;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a2, b2, o2;
  logic        ci2, c2;
  logic [15:0] a4, b4, o4;
  logic        ci4, c4;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  bcd_sub #(.DIGITS(2)) u2 (.clk(clk), .rst(rst), .a(a2), .b(b2), .ci(ci2), .o(o2), .c(c2));
  bcd_sub #(.DIGITS(4)) u4 (.clk(clk), .rst(rst), .a(a4), .b(b4), .ci(ci4), .o(o4), .c(c4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic v2(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ci,
                    input logic [7:0] eo, input logic ec);
    a2 = a; b2 = b; ci2 = ci;
    step();
    chk({tag, ".o"}, 32'(o2), 32'(eo));
    chk({tag, ".c"}, 32'(c2), 32'(ec));
  endtask

  // Decimal reference: convert to integers, subtract, wrap modulo 10^d.
  function automatic void ref_sub(input int d, input logic [15:0] a, input logic [15:0] b,
                                  input logic ci, output logic [15:0] o, output logic c);
    int av = 0, bv = 0, m = 1, diff;
    for (int i = 0; i < d; i++) begin
      av += int'(a[i*4 +: 4]) * m;
      bv += int'(b[i*4 +: 4]) * m;
      m  *= 10;
    end
    diff = av - bv - int'(ci);
    c = (diff < 0);
    if (diff < 0) diff += m;
    o = '0;
    for (int i = 0; i < d; i++) begin
      o[i*4 +: 4] = 4'(diff % 10);
      diff /= 10;
    end
  endfunction

  function automatic logic [15:0] rnd_bcd(input int d);
    logic [15:0] v = '0;
    for (int i = 0; i < d; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] eo;
    logic        ec;

    rst = 1'b1;
    a2 = 8'h45; b2 = 8'h23; ci2 = 1'b0;
    a4 = 16'h1234; b4 = 16'h0001; ci4 = 1'b0;
    step();
    chk("rst.o2", 32'(o2), 32'h0);
    chk("rst.c2", 32'(c2), 32'h0);
    chk("rst.o4", 32'(o4), 32'h0);
    rst = 1'b0;

    // First op after reset lands on the very next edge; consecutive vectors are back-to-back.
    v2("basic",   8'h45, 8'h23, 1'b0, 8'h22, 1'b0);
    v2("under",   8'h23, 8'h45, 1'b0, 8'h78, 1'b1);
    v2("bchain",  8'h50, 8'h01, 1'b0, 8'h49, 1'b0);
    v2("ci_wrap", 8'h00, 8'h00, 1'b1, 8'h99, 1'b1);
    v2("equal",   8'h99, 8'h99, 1'b0, 8'h00, 1'b0);
    v2("ci_mid",  8'h10, 8'h09, 1'b1, 8'h00, 1'b0);
    v2("ci_eq",   8'h37, 8'h37, 1'b1, 8'h99, 1'b1);
    // Non-BCD digits: 0-15 = -15 -> -5 -> 0xB with borrow; upper 0-0-1 -> 9 with borrow.
    v2("bad_lo",  8'h0F, 8'h00, 1'b0, 8'h0F, 1'b0);
    v2("bad_neg", 8'h00, 8'h0F, 1'b0, 8'h9B, 1'b1);

    // Output holds between edges even when inputs change.
    a2 = 8'h45; b2 = 8'h23; ci2 = 1'b0;
    #2;
    chk("hold.o", 32'(o2), 32'h9B);
    chk("hold.c", 32'(c2), 32'h1);

    // Reset wins over operands on the same edge, then normal operation resumes.
    a2 = 8'h23; b2 = 8'h45; ci2 = 1'b0;
    rst = 1'b1;
    step();
    chk("rstmid.o", 32'(o2), 32'h0);
    chk("rstmid.c", 32'(c2), 32'h0);
    rst = 1'b0;
    v2("post_rst", 8'h23, 8'h45, 1'b0, 8'h78, 1'b1);

    // 4-digit directed: 1000 - 0001 ripples a borrow through three digits.
    a4 = 16'h1000; b4 = 16'h0001; ci4 = 1'b0;
    step();
    chk("d4.o", 32'(o4), 32'h0999);
    chk("d4.c", 32'(c4), 32'h0);

    // Random valid-BCD sweep on both widths against the decimal model.
    for (int k = 0; k < 40; k++) begin
      a2 = 8'(rnd_bcd(2)); b2 = 8'(rnd_bcd(2)); ci2 = 1'($urandom_range(0, 1));
      a4 = rnd_bcd(4);     b4 = rnd_bcd(4);     ci4 = 1'($urandom_range(0, 1));
      step();
      ref_sub(2, {8'h0, a2}, {8'h0, b2}, ci2, eo, ec);
      chk("rnd2.o", 32'(o2), 32'(eo[7:0]));
      chk("rnd2.c", 32'(c2), 32'(ec));
      ref_sub(4, a4, b4, ci4, eo, ec);
      chk("rnd4.o", 32'(o4), 32'(eo));
      chk("rnd4.c", 32'(c4), 32'(ec));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
